// File: rtl/muldiv_pkg.sv
// Shared encodings for the signed multiply/divide unit.
//   OP_MUL / OP_DIV : operation select encoding on the op port
//   state_e         : sequencer states
//   DIV0_FILL       : fill bit replicated across c on a divide by zero (all ones)
package muldiv_pkg;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam logic DIV0_FILL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sign_mag_split.sv
// Combinational two's-complement to sign/magnitude conversion.
//   val_i   : WIDTH-bit signed input
//   sign_c_o: sign bit of val_i
//   mag_c_o : |val_i| as WIDTH-bit unsigned; the most negative value maps to 2^(WIDTH-1)
module sign_mag_split #(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] val_i,
    output logic             sign_c_o,
    output logic [WIDTH-1:0] mag_c_o
);

    assign sign_c_o = val_i[WIDTH-1];
    assign mag_c_o  = val_i[WIDTH-1] ? (~val_i + WIDTH'(1)) : val_i;

endmodule

// File: rtl/signed_muldiv_seq.sv
// Sequential signed multiply / divide unit with start/done handshake.
// Result is sign-magnitude: magnitude on c, sign on neg.
//   clk, rst    : clock, synchronous active-high reset
//   start       : request an operation (sampled only in IDLE)
//   op          : 0 = multiply, 1 = divide
//   A, B        : signed operands (multiplicand/dividend, multiplier/divisor)
//   c           : mul |A*B|; div {|remainder|, |quotient|}, quotient in low half
//   neg         : result sign (0 when the product / quotient is zero)
//   busy        : operation in progress
//   done        : one-cycle pulse when c/neg are valid
//   div_by_zero : divide with B == 0, held with the result
module signed_muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   c,
    output logic                 neg,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic               op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               div0_q, div0_d;
    logic [ACC_W-1:0]   c_q, c_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic               a_sign_c, b_sign_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;

    logic [WIDTH:0]     mul_sum;
    logic [ACC_W-1:0]   mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_trial;
    logic [ACC_W-1:0]   div_next;

    sign_mag_split #(.WIDTH(WIDTH)) u_split_a (
        .val_i    (A),
        .sign_c_o (a_sign_c),
        .mag_c_o  (a_mag_c)
    );

    sign_mag_split #(.WIDTH(WIDTH)) u_split_b (
        .val_i    (B),
        .sign_c_o (b_sign_c),
        .mag_c_o  (b_mag_c)
    );

    // One iteration of each algorithm.
    // Multiply: acc = {partial, multiplier}; add |A| to the upper half when the
    // current multiplier LSB is set, then shift the whole pair right (carry included).
    // Divide: acc = {remainder, dividend/quotient}; shift the next dividend bit into
    // the remainder, trial-subtract |B| and restore on borrow; quotient bit enters at LSB.
    always_comb begin
        mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, a_mag_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[ACC_W-2:WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag_q};
        if (div_trial[WIDTH]) begin
            div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        c_d      = c_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    sign_a_d = a_sign_c;
                    sign_b_d = b_sign_c;
                    a_mag_d  = a_mag_c;
                    b_mag_d  = b_mag_c;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    dbz_d    = 1'b0;
                    if (op == OP_DIV && B == '0) begin
                        div0_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        div0_d  = 1'b0;
                        state_d = RUN;
                    end
                    acc_d = (op == OP_MUL) ? {{WIDTH{1'b0}}, b_mag_c}
                                           : {{WIDTH{1'b0}}, a_mag_c};
                end
            end
            RUN: begin
                acc_d = (op_q == OP_DIV) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (div0_q) begin
                    c_d   = {ACC_W{DIV0_FILL}};
                    neg_d = 1'b0;
                    dbz_d = 1'b1;
                end else begin
                    c_d   = acc_q;
                    // A zero product / quotient is always reported positive.
                    neg_d = (sign_a_q ^ sign_b_q) &
                            ((op_q == OP_DIV) ? (|acc_q[WIDTH-1:0]) : (|acc_q));
                    dbz_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            c_q      <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            c_q      <= c_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign c           = c_q;
    assign neg         = neg_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/signed_muldiv_seq.md
Name: signed_muldiv_seq

Overview:
- Parametrised sequential signed multiply/divide unit; successor to the fixed 6-bit multiplier, generalised to WIDTH bits.
- Adds divide mode, start/done handshake, busy flag and divide-by-zero detection.
- Result is sign-magnitude: unsigned magnitude on c, sign on neg.
- Sits in the ALU datapath, where the ALU sequencer stalls on busy.

Parameters:
- WIDTH, 6, operand width in bits; two's-complement signed operands; legal range 4..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- op  input  1  0 = multiply, 1 = divide
- A  input  WIDTH  signed multiplicand / dividend
- B  input  WIDTH  signed multiplier / divisor
- c  output  2*WIDTH  result magnitude; mul: |A*B|; div: {|remainder|, |quotient|}, quotient in c[WIDTH-1:0]
- neg  output  1  result sign; 1 = negative
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when c/neg are valid
- div_by_zero  output  1  set when a divide had B == 0; held with the result

Behaviour:
- One clock domain.
- rst is synchronous and active-high; it overrides everything, including mid-operation.
- Reset values: state=IDLE, c=0, neg=0, busy=0, done=0, div_by_zero=0, internal registers 0.
- States:
  - IDLE -> RUN when start=1 and B != 0 or op=0.
  - IDLE -> DONE when start=1, op=1 and B == 0.
  - RUN -> DONE after exactly WIDTH iterations.
  - DONE -> IDLE unconditionally, after one cycle.
- On accept (edge E0):
  - latch op, sign_a=A[WIDTH-1], sign_b=B[WIDTH-1].
  - latch |A| and |B| as WIDTH-bit unsigned; the most negative value gives magnitude 2^(WIDTH-1), representable.
  - clear div_by_zero; busy=1 from E0.
- Multiply: shift-add, one multiplier bit per RUN cycle (LSB first), 2*WIDTH accumulator.
- Divide: restoring division, one quotient bit per RUN cycle (MSB first).
  - Quotient is truncated toward zero.
  - Remainder magnitude is < |B|.
- Latency:
  - Normal ops: done=1 and c/neg valid in the cycle after edge E0+WIDTH+1 (WIDTH+1 cycles after accept).
  - Divide-by-zero: done after 1 cycle.
- At DONE:
  - busy=0, done=1 for exactly one cycle.
  - c/neg/div_by_zero hold until the next accepted start or rst.
- Sign rule: neg = sign_a XOR sign_b.
  - Forced 0 if the magnitude result (mul product, or div quotient) is zero.
  - The remainder's sign is not reported.
- Divide-by-zero: c = all ones, neg=0, div_by_zero=1.
- start while busy (RUN or DONE) is ignored, with no queuing.
- A/B/op changes during RUN have no effect; operands were latched at accept.
- start high continuously: a new op is accepted on the first IDLE cycle after DONE; throughput is one op per WIDTH+2 cycles.
- rst mid-RUN: abort, all outputs return to reset values, no done pulse.

Decomposition:
- Package muldiv_pkg holds:
  - op encoding: OP_MUL=1'b0, OP_DIV=1'b1.
  - state enum: IDLE, RUN, DONE.
  - DIV0_FILL constant meaning all ones.
- One natural sub-module: sign_mag_split.
  - Combinational WIDTH-bit two's-complement to {sign, magnitude}.
  - Instantiated twice, for A and B.
- Counter, datapath and FSM live in the top module.

Test Plan:
- WIDTH=6, mul A=28, B=2 -> done exactly 7 cycles after accept; c=56, neg=0, div_by_zero=0.
- mul A=-7, B=9 -> c=63, neg=1.
- mul A=-32, B=-5 -> c=160, neg=0.
- mul A=-5, B=0 -> c=0, neg=0 (negative-zero suppression).
- div A=-29, B=5 -> c[5:0]=5, c[11:6]=4, neg=1.
- div A=28, B=2 -> quotient 14, remainder 0, neg=0.
- div A=3, B=-7 -> quotient 0, remainder 3, neg=0.
- div A=17, B=0 -> done 1 cycle after accept; c=12'hFFF, neg=0, div_by_zero=1.
- Handshake:
  - start mul 28*2, then pulse start with A=4, B=2 during RUN -> ignored, result stays 56.
  - Holding start afterwards -> 4*2=8 is accepted in the next IDLE cycle and completes after a further 7 cycles.
- Reset:
  - Assert rst for 1 cycle mid-RUN -> next cycle busy=0, c=0, neg=0, no done pulse.
  - A following start is accepted normally.
